data_receiver_axi_reader: RTL and testbench

- AXI4 read-channel responder that drains the data-receiver FIFO (128-bit measurement words) to the host over AXI4 reads.
- It is the host-facing read end of the path that the write-side FIFO bridge feeds toward the image sender, and it replaces the tied-off data-receiver path (empty=1, dout=0).
- It serves FIFO data bursts and a status word.
- Stalled reads terminate with SLVERR after a timeout.

---
 rtl/data_receiver_axi_reader.sv | 166 ++++++++++++++++
 tb/tb_data_receiver_axi_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_receiver_axi_reader.sv
// AXI4 read responder that drains the data-receiver FIFO to the host.
// Serves FIFO data bursts, a status word, and SLVERR beats on stalls.
module data_receiver_axi_reader #(
  parameter int AXI_ADDR_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int FIFO_COUNT_WIDTH = 17,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [15:0]                 s_axi_arid,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [1:0]                  s_axi_arburst,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [15:0]                 s_axi_aruser,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [15:0]                 s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   fifo_dout,
  input  logic                        fifo_empty,
  input  logic [FIFO_COUNT_WIDTH-1:0] fifo_data_count,
  output logic                        fifo_rd_en
);

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [1:0] REGION_DATA   = 2'd0;
  localparam logic [1:0] REGION_STATUS = 2'd1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      r_state;
  state_t                      w_nextState;
  logic                        r_arready;
  logic                        r_rvalid;
  logic                        r_rlast;
  logic [AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                  r_rresp;
  logic [15:0]                 r_rid;
  logic [1:0]                  r_region;
  logic [8:0]                  r_beatsLeft;
  logic [TO_W-1:0]             r_timeout;

  logic                        w_arHandshake;
  logic                        w_beatAccept;
  logic                        w_slotFree;
  logic                        w_load;
  logic                        w_pop;
  logic                        w_wait;
  logic [AXI_DATA_WIDTH-1:0]   w_loadData;
  logic [1:0]                  w_loadResp;
  logic [AXI_DATA_WIDTH-1:0]   w_status;
  logic                        w_unused;

  assign w_unused = ^{s_axi_arburst, s_axi_arsize, s_axi_aruser, s_axi_araddr};

  always_comb begin
    w_status = '0;
    w_status[16 +: FIFO_COUNT_WIDTH] = fifo_data_count;
    w_status[0] = fifo_empty;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= IDLE;
    else                r_state <= w_nextState;
  end

  // The output register is reloaded only when it is free and a source is ready;
  // an empty FIFO counts wait cycles until an SLVERR beat stands in for data.
  always_comb begin
    w_nextState   = r_state;
    w_arHandshake = s_axi_arvalid && r_arready;
    w_beatAccept  = r_rvalid && s_axi_rready;
    w_slotFree    = !r_rvalid || s_axi_rready;
    w_load        = 1'b0;
    w_pop         = 1'b0;
    w_wait        = 1'b0;
    w_loadData    = '0;
    w_loadResp    = RESP_OKAY;
    case (r_state)
      IDLE: begin
        if (w_arHandshake) w_nextState = BURST;
      end
      BURST: begin
        if (w_slotFree && (r_beatsLeft != 9'd0)) begin
          case (r_region)
            REGION_DATA: begin
              if (!fifo_empty) begin
                w_load     = 1'b1;
                w_pop      = 1'b1;
                w_loadData = fifo_dout;
              end else if (r_timeout == TO_LAST) begin
                w_load     = 1'b1;
                w_loadResp = RESP_SLVERR;
              end else begin
                w_wait = 1'b1;
              end
            end
            REGION_STATUS: begin
              w_load     = 1'b1;
              w_loadData = w_status;
            end
            default: begin
              w_load     = 1'b1;
              w_loadResp = RESP_DECERR;
            end
          endcase
        end
        if (w_beatAccept && r_rlast) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_rid       <= '0;
      r_region    <= '0;
      r_beatsLeft <= '0;
      r_timeout   <= '0;
    end else begin
      r_arready <= (w_nextState == IDLE);
      if (w_arHandshake) begin
        r_rid       <= s_axi_arid;
        r_region    <= s_axi_araddr[5:4];
        r_beatsLeft <= {1'b0, s_axi_arlen} + 9'd1;
        r_timeout   <= '0;
      end
      if (w_load) begin
        r_rvalid    <= 1'b1;
        r_rdata     <= w_loadData;
        r_rresp     <= w_loadResp;
        r_rlast     <= (r_beatsLeft == 9'd1);
        r_beatsLeft <= r_beatsLeft - 9'd1;
        r_timeout   <= '0;
      end else if (w_beatAccept) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
      if (w_wait) r_timeout <= r_timeout + TO_W'(1);
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rid     = r_rid;
  assign fifo_rd_en    = w_pop;

endmodule

// File: tb/tb_data_receiver_axi_reader.sv
// Randomized bench for data_receiver_axi_reader: a queue-backed FIFO feeds the DUT and
// each burst is predicted from the FIFO contents and region rules before it is issued.
module tb_data_receiver_axi_reader;

  localparam int TO = 8;
  localparam logic [127:0] JUNK = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  logic         s_axi_aclk = 1'b0;
  logic         s_axi_aresetn;
  logic [5:0]   s_axi_araddr;
  logic [15:0]  s_axi_arid;
  logic [7:0]   s_axi_arlen;
  logic [1:0]   s_axi_arburst;
  logic [2:0]   s_axi_arsize;
  logic [15:0]  s_axi_aruser;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [15:0]  s_axi_rid;
  logic [127:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [127:0] fifo_dout;
  logic         fifo_empty;
  logic [16:0]  fifo_data_count;
  logic         fifo_rd_en;

  int checks = 0;
  int failures = 0;
  int popCount = 0;
  int badPops = 0;
  int rreadyMode = 0;
  int patIdx = 0;
  longint cycle = 0;
  logic [127:0] fifoQ[$];

  data_receiver_axi_reader #(
    .AXI_ADDR_WIDTH(6),
    .AXI_DATA_WIDTH(128),
    .FIFO_COUNT_WIDTH(17),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .s_axi_aclk(s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arid(s_axi_arid),
    .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_arsize(s_axi_arsize),
    .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_data_count(fifo_data_count),
    .fifo_rd_en(fifo_rd_en)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  always @(posedge s_axi_aclk) cycle++;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic refreshFifo();
    fifo_empty      = (fifoQ.size() == 0);
    fifo_dout       = fifo_empty ? JUNK : fifoQ[0];
    fifo_data_count = 17'(fifoQ.size());
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++)
      fifoQ.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    refreshFifo();
  endtask

  // FWFT FIFO: a pop strobe seen at the edge removes the head just after it.
  always @(posedge s_axi_aclk) begin : fifoModel
    logic doPop;
    doPop = fifo_rd_en;
    #1;
    if (doPop) begin
      if (fifoQ.size() == 0) badPops++;
      else begin
        fifoQ.delete(0);
        popCount++;
      end
    end
    refreshFifo();
  end

  // rready: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1 pattern.
  always @(posedge s_axi_aclk) begin : rreadyDriver
    logic [3:0] pattern;
    pattern = 4'b1001;
    #1;
    case (rreadyMode)
      0: s_axi_rready = 1'b1;
      1: s_axi_rready = 1'($urandom_range(0, 1));
      default: begin
        s_axi_rready = pattern[3 - (patIdx % 4)];
        patIdx++;
      end
    endcase
  end

  task automatic issueAr(input logic [5:0] addr, input logic [7:0] len, input logic [15:0] id,
                         output longint hs, output bit ok);
    int waitCnt;
    waitCnt = 0;
    ok = 1'b0;
    hs = 0;
    @(posedge s_axi_aclk);
    #1;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arid    = id;
    s_axi_arburst = 2'($urandom());
    s_axi_arsize  = 3'($urandom());
    s_axi_aruser  = 16'($urandom());
    s_axi_arvalid = 1'b1;
    while (!ok && waitCnt < 50) begin
      @(negedge s_axi_aclk);
      waitCnt++;
      if (s_axi_arready) begin
        ok = 1'b1;
        hs = cycle + 1;
      end
    end
    checkOutput("arHandshake", 128'(ok), 128'd1);
    if (ok) begin
      @(posedge s_axi_aclk);
      #1;
    end
    s_axi_arvalid = 1'b0;
  endtask

  // Issues one AR and checks every beat against a prediction built from the
  // FIFO snapshot: data words first, SLVERR fill once the FIFO runs dry.
  task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] len, input logic [15:0] id);
    int n, avail, beat, waited, expPops, startPops;
    logic [1:0] region;
    logic [127:0] expData[$];
    logic [1:0] expResp[$];
    logic [127:0] heldData;
    logic [2:0] heldCtl;
    bit stalled, ok;
    longint hs, prev, expGap;
    n = int'(len) + 1;
    avail = fifoQ.size();
    region = addr[5:4];
    startPops = popCount;
    expPops = 0;
    for (int b = 0; b < n; b++) begin
      if (region == 2'd0) begin
        if (b < avail) begin
          expData.push_back(fifoQ[b]);
          expResp.push_back(2'b00);
          expPops++;
        end else begin
          expData.push_back(128'd0);
          expResp.push_back(2'b10);
        end
      end else if (region == 2'd1) begin
        expData.push_back((128'(avail) << 16) | 128'(avail == 0));
        expResp.push_back(2'b00);
      end else begin
        expData.push_back(128'd0);
        expResp.push_back(2'b11);
      end
    end
    issueAr(addr, len, id, hs, ok);
    prev = hs;
    beat = 0;
    waited = 0;
    stalled = 1'b0;
    heldData = '0;
    heldCtl = '0;
    while (ok && beat < n && waited < 3000) begin
      @(negedge s_axi_aclk);
      waited++;
      if (s_axi_rvalid && stalled) begin
        checkOutput("stallData", s_axi_rdata, heldData);
        checkOutput("stallCtl", 128'({s_axi_rresp, s_axi_rlast}), 128'(heldCtl));
      end
      stalled = 1'b0;
      if (s_axi_rvalid && !s_axi_rready) begin
        checkOutput("stallNoPop", 128'(fifo_rd_en), 128'd0);
        stalled  = 1'b1;
        heldData = s_axi_rdata;
        heldCtl  = {s_axi_rresp, s_axi_rlast};
      end else if (s_axi_rvalid) begin
        checkOutput("beatData", s_axi_rdata, expData[beat]);
        checkOutput("beatResp", 128'(s_axi_rresp), 128'(expResp[beat]));
        checkOutput("beatLast", 128'(s_axi_rlast), 128'(beat == n - 1));
        checkOutput("beatRid", 128'(s_axi_rid), 128'(id));
        if (rreadyMode == 0) begin
          expGap = (region == 2'd0 && beat >= avail) ? longint'(TO) : 64'd1;
          checkOutput("beatGap", 128'(cycle - prev), 128'(expGap));
        end
        prev = cycle;
        beat++;
      end
    end
    checkOutput("beatCount", 128'(beat), 128'(n));
    repeat (2) @(negedge s_axi_aclk);
    checkOutput("idleArready", 128'(s_axi_arready), 128'd1);
    checkOutput("idleRvalid", 128'(s_axi_rvalid), 128'd0);
    checkOutput("burstPops", 128'(popCount - startPops), 128'(expPops));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Valid"}, 128'({s_axi_rvalid, s_axi_rlast, s_axi_arready, fifo_rd_en}), 128'd0);
    checkOutput({tag, "Data"}, s_axi_rdata, 128'd0);
    checkOutput({tag, "RespId"}, 128'({s_axi_rresp, s_axi_rid}), 128'd0);
  endtask

  // Drops reset while beat 2 of an 8-beat burst is on the bus.
  task automatic midBurstReset();
    longint hs;
    bit ok;
    int accepts, waited, startPops;
    rreadyMode = 0;
    pushWords(10);
    startPops = popCount;
    issueAr(6'h00, 8'd7, 16'hC3C3, hs, ok);
    accepts = 0;
    waited = 0;
    while (ok && accepts < 2 && waited < 100) begin
      @(negedge s_axi_aclk);
      waited++;
      if (s_axi_rvalid && s_axi_rready) accepts++;
    end
    checkOutput("rstReachedBeat2", 128'(accepts), 128'd2);
    #2 s_axi_aresetn = 1'b0;
    #1 checkResetOutputs("midRst");
    repeat (3) @(negedge s_axi_aclk);
    checkOutput("midRstPops", 128'(popCount - startPops), 128'd2);
    #2 s_axi_aresetn = 1'b1;
    #1 checkOutput("relArreadyLow", 128'(s_axi_arready), 128'd0);
    @(negedge s_axi_aclk);
    checkOutput("relArreadyHigh", 128'(s_axi_arready), 128'd1);
    applyStimulus(6'h00, 8'd0, 16'h0077);
    applyStimulus(6'h00, 8'(fifoQ.size() - 1), 16'h0078);
  endtask

  initial begin
    logic [1:0] region;
    int pick;
    s_axi_aresetn = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arid    = '0;
    s_axi_arlen   = '0;
    s_axi_arburst = '0;
    s_axi_arsize  = '0;
    s_axi_aruser  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    refreshFifo();
    repeat (3) @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
    checkResetOutputs("reset");
    #2 s_axi_aresetn = 1'b1;
    #1 checkOutput("firstArreadyLow", 128'(s_axi_arready), 128'd0);
    @(negedge s_axi_aclk);
    checkOutput("firstArreadyHigh", 128'(s_axi_arready), 128'd1);

    $display("[TB] four-word data burst");
    rreadyMode = 0;
    pushWords(4);
    applyStimulus(6'h00, 8'd3, 16'h005A);

    $display("[TB] status word with 37 words queued");
    pushWords(37);
    applyStimulus(6'h10, 8'd0, 16'h1111);
    applyStimulus(6'h00, 8'd36, 16'h2222);

    $display("[TB] partial burst completed by timeout");
    pushWords(1);
    applyStimulus(6'h00, 8'd1, 16'h3333);
    applyStimulus(6'h10, 8'd0, 16'h3334);

    $display("[TB] invalid region");
    applyStimulus(6'h20, 8'd2, 16'h4444);

    $display("[TB] backpressure pattern");
    rreadyMode = 2;
    patIdx = 0;
    pushWords(4);
    applyStimulus(6'h00, 8'd3, 16'h5555);

    $display("[TB] reset during burst");
    midBurstReset();

    $display("[TB] randomized bursts");
    for (int it = 0; it < 30; it++) begin
      rreadyMode = $urandom_range(0, 2);
      patIdx = 0;
      pushWords($urandom_range(0, 5));
      pick = $urandom_range(0, 9);
      region = (pick < 6) ? 2'd0 : (pick < 8) ? 2'd1 : 2'($urandom_range(2, 3));
      applyStimulus({region, 4'($urandom())}, 8'($urandom_range(0, 5)), 16'($urandom()));
    end

    checkOutput("popWhenEmpty", 128'(badPops), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
